// File: rtl/and_gate.sv
// Bitwise 2-input AND cell with a clocked observer:
// registered copy, per-bit rise pulses and saturating activity counters.
module and_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] C_q,
   output logic [WIDTH-1:0] c_rise,
   output logic [CNT_W-1:0] hi_cnt,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cq;
   logic [WIDTH-1:0] r_rise;
   logic [CNT_W-1:0] r_hi;
   logic [CNT_W-1:0] r_chg;

   logic [WIDTH-1:0] w_c;
   logic             w_all_hi;
   logic             w_changed;
   logic             w_hi_sat;
   logic             w_chg_sat;

   // Core gate: pure combinational, independent of clock and reset
   always_comb begin
      w_c = A & B;
   end

   // Observer conditions derived from the live output and its registered copy
   always_comb begin
      w_all_hi  = &w_c;
      w_changed = (w_c != r_cq);
      w_hi_sat  = &r_hi;
      w_chg_sat = &r_chg;
   end

   // Registered copy of C and rising-edge pulses, frozen while en is low
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cq   <= '0;
         r_rise <= '0;
      end else if (en) begin
         r_cq   <= w_c;
         r_rise <= w_c & ~r_cq;
      end
   end

   // All-ones counter: clr beats increment, saturates instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
      end else if (clr) begin
         r_hi <= '0;
      end else if (en && w_all_hi && !w_hi_sat) begin
         r_hi <= r_hi + CNT_ONE;
      end
   end

   // Change counter: counts cycles where C differs from its registered copy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chg <= '0;
      end else if (clr) begin
         r_chg <= '0;
      end else if (en && w_changed && !w_chg_sat) begin
         r_chg <= r_chg + CNT_ONE;
      end
   end

   assign C       = w_c;
   assign C_q     = r_cq;
   assign c_rise  = r_rise;
   assign hi_cnt  = r_hi;
   assign chg_cnt = r_chg;

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: a 4-bit/16-bit-counter instance
// and a 1-bit/2-bit-counter instance for saturation.
module tb_and_gate;

   typedef struct {
      int          step;
      logic [3:0]  c;
      logic [3:0]  cq;
      logic [3:0]  rise;
      logic [15:0] hi;
      logic [15:0] chg;
   } exp_t;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   bit   clk_on = 1'b0;

   always #5 if (clk_on) clk = ~clk;

   logic        rst4, en4, clr4;
   logic [3:0]  a4, b4, c4, cq4, rise4;
   logic [15:0] hi4, chg4;

   logic        rst1, en1, clr1;
   logic        a1, b1, c1, cq1, rise1;
   logic [1:0]  hi1, chg1;

   and_gate #(.WIDTH(4), .CNT_W(16)) u4 (
      .clk(clk), .rst(rst4), .A(a4), .B(b4), .en(en4), .clr(clr4),
      .C(c4), .C_q(cq4), .c_rise(rise4), .hi_cnt(hi4), .chg_cnt(chg4)
   );

   and_gate #(.WIDTH(1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst1), .A(a1), .B(b1), .en(en1), .clr(clr1),
      .C(c1), .C_q(cq1), .c_rise(rise1), .hi_cnt(hi1), .chg_cnt(chg1)
   );

   exp_t q4[$];
   exp_t q1[$];

   task automatic chk(input string nm, input int step,
                      input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h want %h", nm, step, act, exp);
      end
   endtask

   // Monitor: compares each registered response one delta after the edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("w4_C", e.step, {12'b0, c4}, {12'b0, e.c});
         chk("w4_C_q", e.step, {12'b0, cq4}, {12'b0, e.cq});
         chk("w4_c_rise", e.step, {12'b0, rise4}, {12'b0, e.rise});
         chk("w4_hi_cnt", e.step, hi4, e.hi);
         chk("w4_chg_cnt", e.step, chg4, e.chg);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("w1_C", e.step, {15'b0, c1}, {12'b0, e.c});
         chk("w1_C_q", e.step, {15'b0, cq1}, {12'b0, e.cq});
         chk("w1_c_rise", e.step, {15'b0, rise1}, {12'b0, e.rise});
         chk("w1_hi_cnt", e.step, {14'b0, hi1}, e.hi);
         chk("w1_chg_cnt", e.step, {14'b0, chg1}, e.chg);
      end
   end

   task automatic s4(input int st, input logic r, e, c,
                     input logic [3:0] a, b, ec, eq, er,
                     input logic [15:0] eh, eg);
      exp_t x;
      @(negedge clk);
      rst4 = r; en4 = e; clr4 = c; a4 = a; b4 = b;
      x.step = st; x.c = ec; x.cq = eq; x.rise = er;
      x.hi = eh; x.chg = eg;
      q4.push_back(x);
      @(posedge clk);
   endtask

   task automatic s1(input int st, input logic r, e, c,
                     input logic a, b, ec, eq, er,
                     input logic [15:0] eh, eg);
      exp_t x;
      @(negedge clk);
      rst1 = r; en1 = e; clr1 = c; a1 = a; b1 = b;
      x.step = st; x.c = {3'b0, ec}; x.cq = {3'b0, eq};
      x.rise = {3'b0, er}; x.hi = eh; x.chg = eg;
      q1.push_back(x);
      @(posedge clk);
   endtask

   initial begin
      rst4 = 1'b1; en4 = 1'b0; clr4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      rst1 = 1'b1; en1 = 1'b0; clr1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

      // Combinational path with no clock and reset held
      #10 chk("nc_00", 0, {15'b0, c1}, 16'd0);
      a1 = 1'b0; b1 = 1'b1;
      #10 chk("nc_01", 1, {15'b0, c1}, 16'd0);
      a1 = 1'b1; b1 = 1'b0;
      #10 chk("nc_10", 2, {15'b0, c1}, 16'd0);
      a1 = 1'b1; b1 = 1'b1;
      #10 chk("nc_11", 3, {15'b0, c1}, 16'd1);
      a4 = 4'b1100; b4 = 4'b1010;
      #1 chk("nc_w4", 4, {12'b0, c4}, 16'h0008);

      clk_on = 1'b1;

      // 4-bit instance
      s4(1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
      s4(2, 0, 1, 0, 4'hC, 4'hA, 4'h8, 4'h8, 4'h8, 0, 1);
      s4(3, 0, 1, 0, 4'hC, 4'hA, 4'h8, 4'h8, 4'h0, 0, 1);
      s4(4, 1, 1, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      s4(5, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1);
      s4(6, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 2, 1);
      s4(7, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 3, 1);
      s4(8, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4, 1);
      s4(9, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 5, 1);
      s4(10, 0, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 5, 1);
      s4(11, 0, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 5, 1);
      s4(12, 0, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 5, 1);
      s4(13, 0, 1, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 5, 2);
      s4(14, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 6, 3);
      s4(15, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 6, 3);
      s4(16, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 6, 3);
      s4(17, 0, 1, 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0);
      s4(18, 0, 0, 1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 0, 0);
      s4(19, 1, 1, 1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      s4(20, 0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1);
      s4(21, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1);

      // 1-bit instance with 2-bit counters: saturation then clear
      s1(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      s1(2, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1);
      for (int k = 1; k <= 10; k++) begin
         logic bb;
         logic [15:0] eh, eg;
         bb = (k % 2 == 0);
         eh = (k < 2) ? 16'd1 : (k < 4) ? 16'd2 : 16'd3;
         eg = (k < 2) ? 16'd2 : 16'd3;
         s1(2 + k, 0, 1, 0, 1, bb, bb, bb, bb, eh, eg);
      end
      s1(13, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      s1(14, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0);

      for (int i = 0; i < 10; i++) begin
         if (q4.size() == 0 && q1.size() == 0) break;
         @(posedge clk);
      end
      #3;
      if (q4.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0",
                  q4.size() + q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
